// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter
//   Shares one pipelined FPU datapath between two requesters. Arbitrates,
//   resolves the rounding mode at grant, drives the FPU issue port, tracks
//   in-flight operations in a {valid, src, ill} shift register sized to the
//   FPU latency, steers each result back to its requester and keeps sticky
//   exception flags {IL, OF, NX}.
//
//   Optional feature macro: FPU_ARB_RR_EN
//     defined   -> round-robin arbitration (the requester not granted last
//                  wins on contention; favours requester 0 out of reset)
//     undefined -> fixed priority, requester 0 always wins
//
// Ports
//   CLK, RST                 clock (rising edge), async active-low reset
//   reqN_valid/ready         request handshake; ready is the grant
//   reqN_a, reqN_b           operands
//   reqN_rm                  0-3 static mode, 3'b111 dynamic, 4-6 illegal
//   frm                      global dynamic rounding mode
//   flush                    kill everything in flight and pending issue
//   issue_valid/a/b/rm       FPU issue port
//   fpu_ovf, fpu_nx          FPU result flags, valid LATENCY cycles after issue
//   rsp0_valid, rsp1_valid   one-cycle response strobes
//   rsp_ovf, rsp_nx          flags of the responding operation
//   fflags, fflags_clr       sticky {IL, OF, NX} and its clear
//   busy                     anything in the issue register or pipe
module fpu_issue_arbiter #(
    parameter int LATENCY = 5,
    parameter int DW      = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [2:0]    req0_rm,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [2:0]    req1_rm,
    input  logic [1:0]    frm,
    input  logic          flush,
    output logic          issue_valid,
    output logic [DW-1:0] issue_a,
    output logic [DW-1:0] issue_b,
    output logic [1:0]    issue_rm,
    input  logic          fpu_ovf,
    input  logic          fpu_nx,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic          rsp_ovf,
    output logic          rsp_nx,
    output logic [2:0]    fflags,
    input  logic          fflags_clr,
    output logic          busy
);

    logic          grant0;
    logic          grant1;
    logic [2:0]    sel_rm;
    logic [1:0]    res_rm;
    logic          res_ill;
    logic          iss_src;
    logic          iss_ill;
    logic [LATENCY-1:0] pipe_valid;
    logic [LATENCY-1:0] pipe_src;
    logic [LATENCY-1:0] pipe_ill;
    logic          rsp_fire;

`ifdef FPU_ARB_RR_EN
    // Requester that wins when both are valid.
    logic rr_ptr;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rr_ptr <= 1'b0;
        end else if (grant0 || grant1) begin
            rr_ptr <= grant0;
        end
    end
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!flush) begin
`ifdef FPU_ARB_RR_EN
            if (req0_valid && req1_valid) begin
                grant0 = ~rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
`else
            grant0 = req0_valid;
            grant1 = req1_valid & ~req0_valid;
`endif
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Rounding-mode resolution for whichever requester is granted.
    assign sel_rm = grant1 ? req1_rm : req0_rm;

    always_comb begin
        res_rm  = sel_rm[1:0];
        res_ill = 1'b0;
        if (sel_rm == 3'b111) begin
            res_rm = frm;
        end else if (sel_rm[2]) begin
            res_rm  = 2'b00;
            res_ill = 1'b1;
        end
    end

    // Issue register. flush forces both grants low, so it empties itself.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            issue_valid <= 1'b0;
            issue_a     <= '0;
            issue_b     <= '0;
            issue_rm    <= '0;
            iss_src     <= 1'b0;
            iss_ill     <= 1'b0;
        end else begin
            issue_valid <= grant0 | grant1;
            if (grant0 || grant1) begin
                issue_a  <= grant1 ? req1_a : req0_a;
                issue_b  <= grant1 ? req1_b : req0_b;
                issue_rm <= res_rm;
                iss_src  <= grant1;
                iss_ill  <= res_ill;
            end
        end
    end

    // In-flight pipe; the last entry lines up with the FPU result cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pipe_valid <= '0;
            pipe_src   <= '0;
            pipe_ill   <= '0;
        end else begin
            pipe_valid[0] <= issue_valid & ~flush;
            pipe_src[0]   <= iss_src;
            pipe_ill[0]   <= iss_ill;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1] & ~flush;
                pipe_src[i]   <= pipe_src[i-1];
                pipe_ill[i]   <= pipe_ill[i-1];
            end
        end
    end

    // A result arriving in the flush cycle belongs to a killed operation.
    assign rsp_fire = pipe_valid[LATENCY-1] & ~flush;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_nx     <= 1'b0;
            fflags     <= '0;
        end else begin
            rsp0_valid <= rsp_fire & ~pipe_src[LATENCY-1];
            rsp1_valid <= rsp_fire & pipe_src[LATENCY-1];
            rsp_ovf    <= rsp_fire & fpu_ovf;
            rsp_nx     <= rsp_fire & fpu_nx;
            // Clear first, then OR in this cycle's flags so a set wins.
            fflags     <= (fflags_clr ? 3'b000 : fflags) |
                          (rsp_fire ? {pipe_ill[LATENCY-1], fpu_ovf, fpu_nx} : 3'b000);
        end
    end

    assign busy = issue_valid | (|pipe_valid);

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
module tb_fpu_issue_arbiter;

    localparam int L  = 5;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]    req0_rm = '0, req1_rm = '0;
    logic [1:0]    frm = '0;
    logic          flush = 1'b0;
    logic          issue_valid;
    logic [DW-1:0] issue_a, issue_b;
    logic [1:0]    issue_rm;
    logic          fpu_ovf = 1'b0, fpu_nx = 1'b0;
    logic          rsp0_valid, rsp1_valid, rsp_ovf, rsp_nx;
    logic [2:0]    fflags;
    logic          fflags_clr = 1'b0;
    logic          busy;

    always #5 CLK = ~CLK;

    fpu_issue_arbiter #(.LATENCY(L), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_rm(req0_rm),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_rm(req1_rm),
        .frm(frm), .flush(flush),
        .issue_valid(issue_valid), .issue_a(issue_a), .issue_b(issue_b),
        .issue_rm(issue_rm),
        .fpu_ovf(fpu_ovf), .fpu_nx(fpu_nx),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_ovf(rsp_ovf), .rsp_nx(rsp_nx),
        .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
    );

    // Reference model: a list of live operations with the cycle their
    // response must appear in.
    typedef struct {
        bit src;
        bit ill;
        int rsp_cyc;
    } op_t;

    op_t           q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    bit            m_iss_v;
    logic [DW-1:0] m_a, m_b;
    logic [1:0]    m_rm;
    logic [2:0]    m_ff;
    bit            p_ovf, p_nx, p_clr;
    int            last_g;

    // Stimulus for the next cycle.
    bit            d_v0, d_v1, d_flush, d_clr, d_ovf, d_nx;
    logic [DW-1:0] d_a0, d_b0, d_a1, d_b1;
    logic [2:0]    d_rm0, d_rm1;
    logic [1:0]    d_frm;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic idle();
        d_v0 = 0; d_v1 = 0; d_flush = 0; d_clr = 0; d_ovf = 0; d_nx = 0;
        d_rm0 = 3'd0; d_rm1 = 3'd0; d_frm = 2'd0;
        d_a0 = $urandom; d_b0 = $urandom; d_a1 = $urandom; d_b1 = $urandom;
    endtask

    task automatic model_reset();
        q.delete();
        m_iss_v = 0; m_ff = 3'b000;
        p_ovf = 0; p_nx = 0; p_clr = 0;
        last_g = 1;
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        RST = 1'b0;
        idle();
        req0_valid = 0; req1_valid = 0; flush = 0; fflags_clr = 0;
        fpu_ovf = 0; fpu_nx = 0;
        #1;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_a", issue_a, 0);
        chk("rst_issue_b", issue_b, 0);
        chk("rst_issue_rm", issue_rm, 0);
        chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp_ovf, rsp_nx}, 0);
        chk("rst_fflags", fflags, 0);
        chk("rst_busy", busy, 0);
        model_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    // One clock cycle: check registered outputs against the model, apply the
    // stimulus, check the grant, then advance the model across the edge.
    task automatic step();
        op_t        op;
        bit         resp;
        bit         both;
        int         g;
        logic [2:0] rm;
        logic [1:0] r;
        bit         il;
        @(negedge CLK);
        cyc++;
        resp = 0;
        op   = '{src: 0, ill: 0, rsp_cyc: 0};
        if (q.size() > 0 && q[0].rsp_cyc == cyc) begin
            op   = q.pop_front();
            resp = 1;
        end
        m_ff = (p_clr ? 3'b000 : m_ff) | (resp ? {op.ill, p_ovf, p_nx} : 3'b000);
        chk("rsp0_valid", rsp0_valid, resp && !op.src);
        chk("rsp1_valid", rsp1_valid, resp && op.src);
        chk("rsp_ovf", rsp_ovf, resp && p_ovf);
        chk("rsp_nx", rsp_nx, resp && p_nx);
        chk("fflags", fflags, m_ff);
        chk("issue_valid", issue_valid, m_iss_v);
        chk("busy", busy, q.size() > 0);
        if (m_iss_v) begin
            chk("issue_a", issue_a, m_a);
            chk("issue_b", issue_b, m_b);
            chk("issue_rm", issue_rm, m_rm);
        end

        req0_valid = d_v0; req0_a = d_a0; req0_b = d_b0; req0_rm = d_rm0;
        req1_valid = d_v1; req1_a = d_a1; req1_b = d_b1; req1_rm = d_rm1;
        frm = d_frm; flush = d_flush; fflags_clr = d_clr;
        fpu_ovf = d_ovf; fpu_nx = d_nx;
        #1;

        g = -1;
        both = d_v0 && d_v1;
        if (!d_flush) begin
`ifdef FPU_ARB_RR_EN
            if (both) g = 1 - last_g;
            else if (d_v0) g = 0;
            else if (d_v1) g = 1;
`else
            if (d_v0) g = 0;
            else if (d_v1) g = 1;
`endif
        end
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);

        p_ovf = d_ovf; p_nx = d_nx; p_clr = d_clr;
        m_iss_v = (g >= 0);
        if (g >= 0) begin
            rm = (g == 1) ? d_rm1 : d_rm0;
            il = 0;
            if (rm <= 3'd3) r = rm[1:0];
            else if (rm == 3'd7) r = d_frm;
            else begin r = 2'd0; il = 1; end
            m_a  = (g == 1) ? d_a1 : d_a0;
            m_b  = (g == 1) ? d_b1 : d_b0;
            m_rm = r;
            q.push_back('{src: (g == 1), ill: il, rsp_cyc: cyc + 2 + L});
            last_g = g;
        end
        if (d_flush) q.delete();
    endtask

    int t;

    initial begin
        model_reset();
        idle();
        reset_dut();

        // Contention for four cycles straight after reset.
        t = cyc + 1;
        d_v0 = 1; d_v1 = 1;
        for (int k = 0; k < 4; k++) begin
            step();
`ifdef FPU_ARB_RR_EN
            chk("contend_ready0", req0_ready, (k % 2) == 0);
`else
            chk("contend_ready0", req0_ready, 1);
`endif
        end
        idle();
        while (cyc < t + 2 + L) step();
        chk("contend_rsp0_first", rsp0_valid, 1);
        step();
`ifdef FPU_ARB_RR_EN
        chk("contend_rsp1_second", rsp1_valid, 1);
`else
        chk("contend_rsp1_second", rsp1_valid, 0);
`endif
        repeat (L + 3) step();

        // Single static-mode request.
        t = cyc + 1;
        d_v0 = 1; d_rm0 = 3'b001;
        step();
        idle();
        step();
        chk("single_issue_valid", issue_valid, 1);
        chk("single_issue_rm", issue_rm, 2'b01);
        while (cyc < t + 6) step();
        chk("single_rsp0_early", rsp0_valid, 0);
        step();
        chk("single_rsp0_t7", rsp0_valid, 1);
        chk("single_rsp1_quiet", rsp1_valid, 0);
        repeat (2) step();

        // Dynamic mode samples frm in the grant cycle only.
        d_v1 = 1; d_rm1 = 3'b111; d_frm = 2'b10;
        step();
        idle();
        d_frm = 2'b11;
        step();
        chk("dyn_issue_rm", issue_rm, 2'b10);
        idle();
        repeat (L + 3) step();

        // Six back-to-back operations, inexact on the third result only.
        d_clr = 1; step(); idle();
        t = cyc + 1;
        d_v0 = 1;
        repeat (6) step();
        idle();
        while (cyc < t + 2 + L) step();
        d_nx = 1; step(); d_nx = 0;
        step();
        chk("b2b_rsp_nx_third", rsp_nx, 1);
        chk("b2b_rsp0_third", rsp0_valid, 1);
        repeat (L + 4) step();
        chk("b2b_fflags", fflags, 3'b001);

        // Illegal mode.
        d_clr = 1; step(); idle();
        t = cyc + 1;
        d_v0 = 1; d_rm0 = 3'b101;
        step();
        idle();
        step();
        chk("ill_issue_rm", issue_rm, 2'b00);
        while (cyc < t + 2 + L) step();
        chk("ill_fflags", fflags, 3'b100);

        // Clear and overflow in the same result cycle: set wins.
        t = cyc + 1;
        d_v0 = 1; d_rm0 = 3'b000;
        step();
        idle();
        while (cyc < t + L) step();
        d_clr = 1; d_ovf = 1;
        step();
        idle();
        step();
        chk("clr_set_fflags", fflags, 3'b010);
        chk("clr_set_rsp_ovf", rsp_ovf, 1);

        // Flush two cycles after three grants.
        t = cyc + 1;
        d_v0 = 1;
        repeat (3) step();
        idle();
        d_ovf = 1; d_nx = 1;
        step();
        d_v0 = 1; d_v1 = 1; d_flush = 1;
        step();
        chk("flush_ready0", req0_ready, 0);
        chk("flush_ready1", req1_ready, 0);
        d_v0 = 0; d_v1 = 0; d_flush = 0;
        step();
        chk("flush_busy", busy, 0);
        repeat (L + 3) step();
        chk("flush_fflags", fflags, 3'b010);
        idle();

        // Randomized traffic with one mid-stream reset.
        for (int n = 0; n < 3000; n++) begin
            d_v0    = ($urandom % 10) < 6;
            d_v1    = ($urandom % 10) < 6;
            d_rm0   = 3'($urandom % 8);
            d_rm1   = 3'($urandom % 8);
            d_frm   = 2'($urandom % 4);
            d_a0    = $urandom; d_b0 = $urandom;
            d_a1    = $urandom; d_b1 = $urandom;
            d_flush = ($urandom % 40) == 0;
            d_clr   = ($urandom % 20) == 0;
            d_ovf   = ($urandom % 4) == 0;
            d_nx    = ($urandom % 3) == 0;
            step();
            if (n == 1500) begin
                reset_dut();
                idle();
                repeat (L + 3) step();
            end
        end
        idle();
        repeat (L + 3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_issue_arbiter.md
# fpu_issue_arbiter

Shares the single pipelined FPU datapath between two requesters: requester 0 and requester 1. The normalize/round stage takes a rounding mode and a result sign at issue, delays them internally, and returns a rounded mantissa plus overflow and inexact indications a fixed number of cycles later.

This block does the following:
- arbitrates between the two requesters and resolves each operation's rounding mode (static or dynamic);
- drives the FPU issue port;
- tracks every in-flight operation in a valid/source shift register matched to the pipeline depth;
- steers each returning result to the requester that issued it;
- accumulates sticky exception flags.

## Interface
Parameters:
- LATENCY, 5, cycles from `issue_valid` high to the FPU result being valid at `fpu_*` inputs (≥1).
- DW, 32, operand width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  grant to requester 0; transfer when valid&ready.
- req0_a, req0_b  in  DW  operands from requester 0.
- req0_rm  in  3  rounding mode: 0–3 static (Near/Zero/+Inf/−Inf), 3'b111 dynamic, 3'b100–3'b110 illegal.
- req1_valid, req1_ready, req1_a, req1_b, req1_rm  same set for requester 1.
- frm  in  2  global dynamic rounding mode.
- flush  in  1  kill all in-flight and pending issue.
- issue_valid  out  1  operation presented to the FPU this cycle.
- issue_a, issue_b  out  DW  operands to the FPU.
- issue_rm  out  2  to the FPU `R_mode_ext`.
- fpu_ovf  in  1  FPU overflow-after-round.
- fpu_nx  in  1  FPU inexact.
- rsp0_valid, rsp1_valid  out  1  one-cycle response strobe per requester; no backpressure.
- rsp_ovf, rsp_nx  out  1  flags of the responding operation.
- fflags  out  3  sticky {IL, OF, NX}.
- fflags_clr  in  1  clear sticky flags.
- busy  out  1  any operation in flight or in the issue register.

## Operation
Arbitration:
- At most one grant per cycle.
- `reqN_ready` is combinational and is low whenever `flush` is high.

Rounding-mode resolution, done at grant:
- Static `rm` passes through to `issue_rm`.
- 3'b111 takes `frm` as sampled in the grant cycle.
- Illegal codes issue with mode 2'b00 (Near) and mark the operation illegal.

Issue register:
- Captures operands, resolved mode, source ID and illegal bit at grant.
- `issue_valid` is high for exactly one cycle per grant.

In-flight pipe:
- The pipe is LATENCY entries of {valid, src, ill}.
- Entry 0 loads from the issue register.
- The last entry marks the FPU result cycle. In that cycle the block registers `fpu_ovf` and `fpu_nx` into `rsp_ovf` and `rsp_nx`, and pulses `rsp<src>_valid`.

Sticky flags:
- `fflags` OR in {ill, ovf, nx} at each response.
- `fflags_clr` clears them.
- When clear and set happen in the same cycle, set wins: flags raised that cycle remain.

Flush:
- Clears the issue register and all pipe valid bits in the same edge.
- Flushed operations produce no response and no flag update.
- The FPU keeps computing them; their results are ignored.

States: no FSM. Occupancy is implied by the pipe.

## Timing
- Grant in cycle t.
- `issue_valid` at t+1.
- FPU result at t+1+LATENCY.
- `rspN_valid`, `rsp_ovf`, `rsp_nx` and the `fflags` update at t+2+LATENCY.
- Full throughput: one issue per cycle and back-to-back responses, in issue order.
- Reset values: all pipe valid bits 0, `issue_valid` 0, `issue_a`/`issue_b`/`issue_rm` 0, `rsp*` 0, `fflags` 0, `busy` 0, round-robin pointer favours requester 0.
- Reset mid-operation discards everything in flight. No response is produced after RST deasserts.
- `busy` is combinational: OR of the issue register valid and all pipe valid bits.

## Configuration
- FPU_ARB_RR_EN defined: round-robin arbitration.
  - The pointer toggles to the other requester after each grant.
  - When both requesters are valid, the requester not granted last wins.
- FPU_ARB_RR_EN undefined: fixed priority.
  - Requester 0 always wins.
  - Requester 1 is granted only when `req0_valid` is low.

## Test plan
- Single request, req0 with rm=3'b001: `issue_valid` at t+1 with `issue_rm`=01; `rsp0_valid` at t+7 (LATENCY=5); `rsp1_valid` stays 0.
- Dynamic mode: req1 with rm=3'b111 and frm=2'b10 at grant, frm changed to 2'b11 the next cycle: `issue_rm`=10.
- Both requesters valid for 4 cycles, RR_EN on: grants 0,1,0,1 and responses 0,1,0,1. RR_EN off: grants 0,0,0,0.
- Back-to-back: 6 consecutive grants with `fpu_nx` high on the 3rd result only: six responses on consecutive cycles, `rsp_nx` high on the 3rd only, `fflags`=3'b001 afterwards.
- Illegal rm=3'b101 on req0: `issue_rm`=00; at the response `fflags[2]`=1. `fflags_clr` on the same cycle as a response with `fpu_ovf`=1: `fflags`=3'b010.
- `flush` two cycles after 3 grants: no `rsp*_valid` for those operations, `fflags` unchanged, `busy`=0 the cycle after flush, and `reqN_ready`=0 during the flush cycle.
